// File: rtl/inv_add_round_key_mix_columns.sv
// AES-128 decryption stage: AddRoundKey followed by InvMixColumns.
// Column-serial by default; define AES_INV_MC_PARALLEL_EN for one-cycle InvMixColumns.
module inv_add_round_key_mix_columns #(
  parameter bit CLEAR_ON_IDLE = 1'b0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [0:127] STATE_IN,
  input  logic [0:127] ROUND_KEY,
  input  logic         LAST_ROUND,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [0:127] STATE_OUT,
  output logic         BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [0:127] r_s;
  logic [0:127] r_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mc(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef AES_INV_MC_PARALLEL_EN
  logic [0:127] w_mc_all;

  assign w_mc_all = {inv_mc(r_s[0:31]),
                     inv_mc(r_s[32:63]),
                     inv_mc(r_s[64:95]),
                     inv_mc(r_s[96:127])};
`else
  logic [1:0]  r_col;
  logic [31:0] w_col;
  logic [31:0] w_mc;

  // One shared InvMixColumn datapath behind a column mux
  assign w_col = r_s[{r_col, 5'd0} +: 32];
  assign w_mc  = inv_mc(w_col);
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (IN_VALID) w_next = LAST_ROUND ? S_DONE : S_BUSY;
`ifdef AES_INV_MC_PARALLEL_EN
      S_BUSY: w_next = S_DONE;
`else
      S_BUSY: if (r_col == 2'd3) w_next = S_DONE;
`endif
      S_DONE: if (OUT_READY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_out   <= '0;
`ifndef AES_INV_MC_PARALLEL_EN
      r_col   <= 2'd0;
`endif
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (IN_VALID) r_s <= STATE_IN ^ ROUND_KEY;
`ifndef AES_INV_MC_PARALLEL_EN
          r_col <= 2'd0;
`endif
        end
        S_BUSY: begin
`ifdef AES_INV_MC_PARALLEL_EN
          r_s <= w_mc_all;
`else
          r_s[{r_col, 5'd0} +: 32] <= w_mc;
          r_col <= r_col + 2'd1;
`endif
        end
        S_DONE: r_out <= CLEAR_ON_IDLE ? '0 : r_s;
        default: ;
      endcase
    end
  end

  // r_out is what STATE_OUT shows once the stage leaves DONE
  assign STATE_OUT = (r_state == S_DONE) ? r_s : r_out;
  assign OUT_VALID = (r_state == S_DONE);
  assign IN_READY  = (r_state == S_IDLE);
  assign BUSY      = (r_state == S_BUSY);

endmodule

// File: tb/tb_inv_add_round_key_mix_columns.sv
// Bench for inv_add_round_key_mix_columns: vector table, stall, reset and
// back-to-back throughput sequences with a queue-based scoreboard.
module tb_inv_add_round_key_mix_columns;

`ifdef AES_INV_MC_PARALLEL_EN
  localparam int NL_LAT = 2;
  localparam int NL_GAP = 3;
`else
  localparam int NL_LAT = 5;
  localparam int NL_GAP = 6;
`endif

  logic         clk = 1'b0;
  logic         RST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [0:127] STATE_IN;
  logic [0:127] ROUND_KEY;
  logic         LAST_ROUND;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [0:127] STATE_OUT;
  logic         BUSY;

  inv_add_round_key_mix_columns dut (
    .CLK(clk),
    .RST(RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .STATE_IN(STATE_IN),
    .ROUND_KEY(ROUND_KEY),
    .LAST_ROUND(LAST_ROUND),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .STATE_OUT(STATE_OUT),
    .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:127] st;
    logic [0:127] key;
    logic         last;
    logic [0:127] exp;
  } vec_t;

  typedef struct {
    logic [0:127] exp;
    int           t;
    logic         last;
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  seen_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_mc(input logic [31:0] col);
    logic [7:0] k [4];
    logic [7:0] a [4];
    logic [7:0] b [4];
    k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      b[r] = 8'h00;
      for (int j = 0; j < 4; j++) b[r] ^= gmul(k[(j - r) & 3], a[j]);
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [0:127] model(input logic [0:127] st,
                                         input logic [0:127] key,
                                         input logic last);
    logic [0:127] s;
    s = st ^ key;
    if (!last)
      for (int c = 0; c < 4; c++) s[32*c +: 32] = ref_mc(s[32*c +: 32]);
    return s;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom} | 128'h1;
  endfunction

  // Output-side scoreboard: latency on first OUT_VALID, data on handshake
  always @(negedge clk) begin
    if (RST) begin
      q.delete();
      seen_v = 0;
    end else if (OUT_VALID) begin
      chk("valid_has_block", {127'd0, q.size() != 0}, 128'd1);
      if (q.size() != 0) begin
        if (!seen_v) begin
          seen_v = 1;
          chk("latency", 128'(cyc - q[0].t), 128'(q[0].last ? 1 : NL_LAT));
        end
        if (OUT_READY) begin
          chk("data", STATE_OUT, q[0].exp);
          void'(q.pop_front());
          seen_v = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic send(input logic [0:127] st, input logic [0:127] key,
                      input logic last, input logic [0:127] exp,
                      input bit keep, output int t);
    bit ok = 0;
    STATE_IN   = st;
    ROUND_KEY  = key;
    LAST_ROUND = last;
    IN_VALID   = 1'b1;
    t = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (IN_READY) begin
        ok = 1;
        t  = cyc;
        q.push_back('{exp, cyc, last});
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout got=none exp=accept");
    end
    @(posedge clk);
    #1;
    IN_VALID = keep;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q.size() != 0 || OUT_VALID); i++)
      @(negedge clk);
    chk("drain", 128'(q.size()), 128'd0);
  endtask

  vec_t         tbl [5];
  logic [0:127] v0_exp;
  int           t, nv;
  int           acc [8];
  logic         lst [8];

  initial begin
    v0_exp = 128'hdb135345_01010101_c6c6c6c6_f20a225c;
    tbl[0] = '{128'h8e4da1bc_01010101_c6c6c6c6_9fdc589d, 128'h0, 1'b0, v0_exp};
    tbl[1] = '{128'h00112233445566778899aabbccddeeff,
               128'h000102030405060708090a0b0c0d0e0f, 1'b1,
               128'h00102030405060708090a0b0c0d0e0f0};
    tbl[2].st = rnd128();
    tbl[2].key = tbl[2].st;
    tbl[2].last = 1'b0;
    tbl[2].exp = 128'h0;
    for (int i = 3; i < 5; i++) begin
      tbl[i].st   = rnd128();
      tbl[i].key  = rnd128();
      tbl[i].last = (i == 4);
      tbl[i].exp  = model(tbl[i].st, tbl[i].key, tbl[i].last);
    end

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    STATE_IN = '0; ROUND_KEY = '0; LAST_ROUND = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b0;
    chk("rst_in_ready", 128'(IN_READY), 128'd1);
    chk("rst_out_valid", 128'(OUT_VALID), 128'd0);
    chk("rst_busy", 128'(BUSY), 128'd0);
    chk("rst_state_out", STATE_OUT, 128'd0);

    OUT_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      send(tbl[i].st, tbl[i].key, tbl[i].last, tbl[i].exp, 1'b0, t);
      wait_drain();
    end

    // Stall with OUT_READY low and a second block offered meanwhile
    @(posedge clk);
    #1;
    OUT_READY = 1'b0;
    send(tbl[0].st, tbl[0].key, 1'b0, v0_exp, 1'b0, t);
    for (int i = 0; i < 20 && !OUT_VALID; i++) @(negedge clk);
    chk("stall_reach_done", 128'(OUT_VALID), 128'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      IN_VALID = (i == 2);
      STATE_IN = tbl[3].st;
      ROUND_KEY = tbl[3].key;
      @(negedge clk);
      chk("stall_valid", 128'(OUT_VALID), 128'd1);
      chk("stall_data", STATE_OUT, v0_exp);
      chk("stall_in_ready", 128'(IN_READY), 128'd0);
    end
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 128'(IN_READY), 128'd1);
    chk("release_out_valid", 128'(OUT_VALID), 128'd0);
    chk("release_hold", STATE_OUT, v0_exp);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (OUT_VALID) nv++;
    end
    chk("no_second_block", 128'(nv), 128'd0);

    // Reset two cycles into a non-last block
    @(posedge clk);
    #1;
    send(tbl[0].st, tbl[0].key, 1'b0, v0_exp, 1'b0, t);
    @(posedge clk);
    #1;
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    chk("mid_rst_out_valid", 128'(OUT_VALID), 128'd0);
    chk("mid_rst_busy", 128'(BUSY), 128'd0);
    chk("mid_rst_in_ready", 128'(IN_READY), 128'd1);
    chk("mid_rst_state_out", STATE_OUT, 128'd0);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (OUT_VALID) nv++;
    end
    chk("mid_rst_no_output", 128'(nv), 128'd0);

    // Back-to-back blocks, alternating last-round flag
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      logic [0:127] s, k;
      s = rnd128();
      k = rnd128();
      lst[i] = i[0];
      send(s, k, lst[i], model(s, k, lst[i]), i != 7, acc[i]);
    end
    for (int i = 1; i < 8; i++)
      chk("accept_gap", 128'(acc[i] - acc[i-1]),
          128'(lst[i-1] ? 2 : NL_GAP));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
